decode_issue_stage: RTL and testbench

//  Next-generation decode stage: field extraction, scalar and vector register files, per-register scoreboard,
//  RAW-hazard stall, and a registered ID/EX output slot with valid/ready handshake on both sides.

---
 rtl/decode_issue_stage.sv | 203 ++++++++++++++++++++
 tb/tb_decode_issue_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_issue_stage
// Description : Decode stage. Extracts instruction fields, reads scalar and
//               vector register files (with writeback write-through), tracks
//               pending destinations in a per-register scoreboard, stalls on
//               RAW hazards and holds the decoded instruction in a registered
//               ID/EX slot with valid/ready handshakes on both sides.
// Ports       :
//   clock, reset (async, active-high)
//   inValid/inReady/instruction        : fetch-side handshake
//   flush                              : kill the instruction in the slot
//   writeEnableScalar/Vector, writeAddress,
//   writeScalarData/writeVectorData    : writeback ports
//   outValid/outReady                  : execute-side handshake
//   opcode, reg*Address, inmediate, isVector, writesDest,
//   reg1/2ScalarContent, reg1/2VectorContent : registered slot contents
//   stallCycles                        : saturating hazard-stall counter
// Revision    : 1.0 - initial release
// ============================================================================
module decode_issue_stage #(
  parameter int DATA_WIDTH        = 8,
  parameter int VECTOR_SIZE       = 6,
  parameter int SCALAR_REGNUM     = 8,
  parameter int VECTOR_REGNUM     = 8,
  parameter int ADDRESS_WIDTH     = 3,
  parameter int OPCODE_WIDTH      = 5,
  parameter int INSTRUCTION_WIDTH = 30
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              inValid,
  output logic                              inReady,
  input  logic [INSTRUCTION_WIDTH-1:0]      instruction,
  input  logic                              flush,
  input  logic                              writeEnableScalar,
  input  logic                              writeEnableVector,
  input  logic [ADDRESS_WIDTH-1:0]          writeAddress,
  input  logic [DATA_WIDTH-1:0]             writeScalarData,
  input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] writeVectorData,
  output logic                              outValid,
  input  logic                              outReady,
  output logic [OPCODE_WIDTH-1:0]           opcode,
  output logic [ADDRESS_WIDTH-1:0]          regDestinationAddress,
  output logic [ADDRESS_WIDTH-1:0]          reg1Address,
  output logic [ADDRESS_WIDTH-1:0]          reg2Address,
  output logic [DATA_WIDTH-1:0]             inmediate,
  output logic                              isVector,
  output logic                              writesDest,
  output logic [DATA_WIDTH-1:0]             reg1ScalarContent,
  output logic [DATA_WIDTH-1:0]             reg2ScalarContent,
  output logic [VECTOR_SIZE*DATA_WIDTH-1:0] reg1VectorContent,
  output logic [VECTOR_SIZE*DATA_WIDTH-1:0] reg2VectorContent,
  output logic [15:0]                       stallCycles
);

  localparam int L  = INSTRUCTION_WIDTH;
  localparam int O  = OPCODE_WIDTH;
  localparam int A  = ADDRESS_WIDTH;
  localparam int VW = VECTOR_SIZE * DATA_WIDTH;

  // Field extraction
  logic [O-1:0] dec_opcode;
  logic [A-1:0] dec_rd, dec_rs1, dec_rs2;
  logic         dec_is_vector, dec_writes;

  assign dec_opcode    = instruction[L-1 -: O];
  assign dec_rd        = instruction[L-O-1 -: A];
  assign dec_rs1       = instruction[L-O-A-1 -: A];
  assign dec_rs2       = instruction[L-O-2*A-1 -: A];
  assign dec_is_vector = dec_opcode[O-1];
  assign dec_writes    = (dec_opcode != '0) && (dec_rd != '0);

  // Register files and scoreboard
  logic [DATA_WIDTH-1:0] sregs [SCALAR_REGNUM];
  logic [VW-1:0]         vregs [VECTOR_REGNUM];
  logic [SCALAR_REGNUM-1:0] pend_s, pend_s_nxt;
  logic [VECTOR_REGNUM-1:0] pend_v, pend_v_nxt;

  logic wb_s, wb_v;
  assign wb_s = writeEnableScalar && (writeAddress != '0);
  assign wb_v = writeEnableVector && (writeAddress != '0);

  // Operand reads; a writeback landing this cycle is forwarded so that a
  // reader released by that same writeback picks up the fresh value.
  logic [DATA_WIDTH-1:0] rs1_s, rs2_s;
  logic [VW-1:0]         rs1_v, rs2_v;

  always_comb begin
    rs1_s = '0;
    rs2_s = '0;
    rs1_v = '0;
    rs2_v = '0;
    if (dec_rs1 != '0) begin
      rs1_s = (wb_s && writeAddress == dec_rs1) ? writeScalarData : sregs[dec_rs1];
      rs1_v = (wb_v && writeAddress == dec_rs1) ? writeVectorData : vregs[dec_rs1];
    end
    if (dec_rs2 != '0) begin
      rs2_s = (wb_s && writeAddress == dec_rs2) ? writeScalarData : sregs[dec_rs2];
      rs2_v = (wb_v && writeAddress == dec_rs2) ? writeVectorData : vregs[dec_rs2];
    end
  end

  // A source is busy if pending and not being retired by writeback right now.
  logic busy1, busy2, hazard, accept;

  always_comb begin
    busy1 = 1'b0;
    busy2 = 1'b0;
    if (dec_rs1 != '0) begin
      if (dec_is_vector) busy1 = pend_v[dec_rs1] && !(wb_v && writeAddress == dec_rs1);
      else               busy1 = pend_s[dec_rs1] && !(wb_s && writeAddress == dec_rs1);
    end
    if (dec_rs2 != '0) begin
      if (dec_is_vector) busy2 = pend_v[dec_rs2] && !(wb_v && writeAddress == dec_rs2);
      else               busy2 = pend_s[dec_rs2] && !(wb_s && writeAddress == dec_rs2);
    end
  end

  assign hazard  = busy1 || busy2;
  assign inReady = !hazard && (!outValid || outReady) && !flush;
  assign accept  = inValid && inReady;

  // Scoreboard update order: clears first, then a set from an accept, so a
  // same-cycle set and clear of one register leaves it pending.
  always_comb begin
    pend_s_nxt = pend_s;
    pend_v_nxt = pend_v;
    if (wb_s) pend_s_nxt[writeAddress] = 1'b0;
    if (wb_v) pend_v_nxt[writeAddress] = 1'b0;
    // A flushed writer never writes back, so release its destination.
    if (flush && outValid && writesDest) begin
      if (isVector) pend_v_nxt[regDestinationAddress] = 1'b0;
      else          pend_s_nxt[regDestinationAddress] = 1'b0;
    end
    if (accept && dec_writes) begin
      if (dec_is_vector) pend_v_nxt[dec_rd] = 1'b1;
      else               pend_s_nxt[dec_rd] = 1'b1;
    end
    pend_s_nxt[0] = 1'b0;
    pend_v_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SCALAR_REGNUM; i++) sregs[i] <= '0;
      for (int i = 0; i < VECTOR_REGNUM; i++) vregs[i] <= '0;
      pend_s <= '0;
      pend_v <= '0;
    end else begin
      if (wb_s) sregs[writeAddress] <= writeScalarData;
      if (wb_v) vregs[writeAddress] <= writeVectorData;
      pend_s <= pend_s_nxt;
      pend_v <= pend_v_nxt;
    end
  end

  // ID/EX output slot
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outValid              <= 1'b0;
      opcode                <= '0;
      regDestinationAddress <= '0;
      reg1Address           <= '0;
      reg2Address           <= '0;
      inmediate             <= '0;
      isVector              <= 1'b0;
      writesDest            <= 1'b0;
      reg1ScalarContent     <= '0;
      reg2ScalarContent     <= '0;
      reg1VectorContent     <= '0;
      reg2VectorContent     <= '0;
    end else if (flush) begin
      outValid <= 1'b0;
    end else if (accept) begin
      outValid              <= 1'b1;
      opcode                <= dec_opcode;
      regDestinationAddress <= dec_rd;
      reg1Address           <= dec_rs1;
      reg2Address           <= dec_rs2;
      inmediate             <= instruction[DATA_WIDTH-1:0];
      isVector              <= dec_is_vector;
      writesDest            <= dec_writes;
      reg1ScalarContent     <= rs1_s;
      reg2ScalarContent     <= rs2_s;
      reg1VectorContent     <= rs1_v;
      reg2VectorContent     <= rs2_v;
    end else if (outReady) begin
      outValid <= 1'b0;
    end
  end

  // Hazard-stall counter, saturating
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stallCycles <= '0;
    end else if (inValid && hazard && stallCycles != 16'hFFFF) begin
      stallCycles <= stallCycles + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_issue_stage
// Description : Directed self-checking bench for decode_issue_stage.
//               Inputs change on the falling edge; outputs are sampled on the
//               falling edge or shortly after an input change.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_issue_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        inValid, inReady, flush;
  logic [29:0] instruction;
  logic        writeEnableScalar, writeEnableVector;
  logic [2:0]  writeAddress;
  logic [7:0]  writeScalarData;
  logic [47:0] writeVectorData;
  logic        outValid, outReady;
  logic [4:0]  opcode;
  logic [2:0]  regDestinationAddress, reg1Address, reg2Address;
  logic [7:0]  inmediate;
  logic        isVector, writesDest;
  logic [7:0]  reg1ScalarContent, reg2ScalarContent;
  logic [47:0] reg1VectorContent, reg2VectorContent;
  logic [15:0] stallCycles;

  int compared   = 0;
  int mismatched = 0;

  localparam logic [47:0] VDATA = 48'hA1B2C3D4E5F6;

  decode_issue_stage dut (
    .clock(clock), .reset(reset), .inValid(inValid), .inReady(inReady),
    .instruction(instruction), .flush(flush),
    .writeEnableScalar(writeEnableScalar), .writeEnableVector(writeEnableVector),
    .writeAddress(writeAddress), .writeScalarData(writeScalarData),
    .writeVectorData(writeVectorData), .outValid(outValid), .outReady(outReady),
    .opcode(opcode), .regDestinationAddress(regDestinationAddress),
    .reg1Address(reg1Address), .reg2Address(reg2Address), .inmediate(inmediate),
    .isVector(isVector), .writesDest(writesDest),
    .reg1ScalarContent(reg1ScalarContent), .reg2ScalarContent(reg2ScalarContent),
    .reg1VectorContent(reg1VectorContent), .reg2VectorContent(reg2VectorContent),
    .stallCycles(stallCycles)
  );

  always #5 clock = ~clock;

  function automatic logic [29:0] mk(input logic [4:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2,
                                     input logic [7:0] imm);
    return {op, rd, rs1, rs2, 8'h00, imm};
  endfunction

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle;
    inValid = 0; flush = 0; outReady = 1; instruction = '0;
    writeEnableScalar = 0; writeEnableVector = 0; writeAddress = '0;
    writeScalarData = '0; writeVectorData = '0;
  endtask

  task automatic test_reset;
    idle();
    reset = 1;
    repeat (2) @(negedge clock);
    reset = 0;
    #1;
    compared++; if (outValid !== 1'b0) begin mismatched++; $display("FAIL reset_outValid: got %b want 0", outValid); end
    compared++; if (stallCycles !== 16'h0) begin mismatched++; $display("FAIL reset_stall: got %h want 0000", stallCycles); end
    compared++; if (opcode !== 5'h0) begin mismatched++; $display("FAIL reset_opcode: got %h want 00", opcode); end
    compared++; if (inReady !== 1'b1) begin mismatched++; $display("FAIL reset_inReady: got %b want 1", inReady); end
    @(negedge clock);
  endtask

  task automatic test_scalar_read;
    writeEnableScalar = 1; writeAddress = 3'd3; writeScalarData = 8'h5A;
    tick();
    idle();
    inValid = 1; instruction = mk(5'h01, 3'd0, 3'd3, 3'd0, 8'hC3);
    #1;
    compared++; if (inReady !== 1'b1) begin mismatched++; $display("FAIL scalar_inReady: got %b want 1", inReady); end
    tick();
    idle();
    compared++; if (outValid !== 1'b1) begin mismatched++; $display("FAIL scalar_outValid: got %b want 1", outValid); end
    compared++; if (reg1ScalarContent !== 8'h5A) begin mismatched++; $display("FAIL scalar_rs1: got %h want 5a", reg1ScalarContent); end
    compared++; if ({opcode, reg1Address, inmediate, writesDest, isVector} !== {5'h01, 3'd3, 8'hC3, 1'b0, 1'b0})
      begin mismatched++; $display("FAIL scalar_fields: got %h %h %h %b %b want 01 3 c3 0 0", opcode, reg1Address, inmediate, writesDest, isVector); end
    // same-cycle write to r5 is forwarded to rs2
    inValid = 1; instruction = mk(5'h01, 3'd0, 3'd3, 3'd5, 8'h00);
    writeEnableScalar = 1; writeAddress = 3'd5; writeScalarData = 8'h77;
    tick();
    idle();
    compared++; if ({reg1ScalarContent, reg2ScalarContent} !== {8'h5A, 8'h77})
      begin mismatched++; $display("FAIL scalar_bypass: got %h %h want 5a 77", reg1ScalarContent, reg2ScalarContent); end
    tick();
    compared++; if (outValid !== 1'b0) begin mismatched++; $display("FAIL scalar_drain: got %b want 0", outValid); end
  endtask

  task automatic test_raw_stall;
    inValid = 1; instruction = mk(5'h01, 3'd2, 3'd0, 3'd0, 8'h00);
    tick();
    instruction = mk(5'h01, 3'd0, 3'd2, 3'd0, 8'h00);
    #1;
    compared++; if (inReady !== 1'b0) begin mismatched++; $display("FAIL raw_inReady: got %b want 0", inReady); end
    repeat (3) tick();
    compared++; if (stallCycles !== 16'd3) begin mismatched++; $display("FAIL raw_stallCount: got %0d want 3", stallCycles); end
    compared++; if (outValid !== 1'b0) begin mismatched++; $display("FAIL raw_slotDrained: got %b want 0", outValid); end
    writeEnableScalar = 1; writeAddress = 3'd2; writeScalarData = 8'h11;
    #1;
    compared++; if (inReady !== 1'b1) begin mismatched++; $display("FAIL raw_release: got %b want 1", inReady); end
    tick();
    writeEnableScalar = 0;
    compared++; if ({outValid, reg1ScalarContent} !== {1'b1, 8'h11}) begin mismatched++; $display("FAIL raw_bypass: got %b %h want 1 11", outValid, reg1ScalarContent); end
    compared++; if (stallCycles !== 16'd3) begin mismatched++; $display("FAIL raw_noExtraStall: got %0d want 3", stallCycles); end
    #1;
    compared++; if (inReady !== 1'b1) begin mismatched++; $display("FAIL raw_pendingCleared: got %b want 1", inReady); end
    idle();
    tick();
  endtask

  task automatic test_vector_hold_flush;
    writeEnableVector = 1; writeAddress = 3'd1; writeVectorData = VDATA;
    tick();
    idle();
    outReady = 0; inValid = 1; instruction = mk(5'h10, 3'd4, 3'd1, 3'd0, 8'h00);
    tick();
    instruction = mk(5'h01, 3'd0, 3'd0, 3'd0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      compared++; if ({outValid, opcode, isVector, writesDest, regDestinationAddress} !== {1'b1, 5'h10, 1'b1, 1'b1, 3'd4})
        begin mismatched++; $display("FAIL vec_hold%0d: got %b %h %b %b %h want 1 10 1 1 4", i, outValid, opcode, isVector, writesDest, regDestinationAddress); end
      compared++; if (reg1VectorContent !== VDATA) begin mismatched++; $display("FAIL vec_data%0d: got %h want %h", i, reg1VectorContent, VDATA); end
      compared++; if (inReady !== 1'b0) begin mismatched++; $display("FAIL vec_inReady%0d: got %b want 0", i, inReady); end
      tick();
    end
    flush = 1;
    #1;
    compared++; if (inReady !== 1'b0) begin mismatched++; $display("FAIL flush_inReady: got %b want 0", inReady); end
    tick();
    flush = 0;
    compared++; if (outValid !== 1'b0) begin mismatched++; $display("FAIL flush_outValid: got %b want 0", outValid); end
    outReady = 1; instruction = mk(5'h10, 3'd0, 3'd4, 3'd0, 8'h00);
    #1;
    compared++; if (inReady !== 1'b1) begin mismatched++; $display("FAIL flush_v4Pending: got %b want 1", inReady); end
    compared++; if (stallCycles !== 16'd3) begin mismatched++; $display("FAIL vec_noStall: got %0d want 3", stallCycles); end
    idle();
    tick();
  endtask

  task automatic test_zero_reg;
    inValid = 1; instruction = mk(5'h00, 3'd3, 3'd0, 3'd0, 8'h00);
    tick();
    compared++; if ({outValid, writesDest} !== 2'b10) begin mismatched++; $display("FAIL nop_writesDest: got %b %b want 1 0", outValid, writesDest); end
    instruction = mk(5'h01, 3'd0, 3'd3, 3'd0, 8'h00);
    #1;
    compared++; if (inReady !== 1'b1) begin mismatched++; $display("FAIL nop_noStall: got %b want 1", inReady); end
    // rd=0 writer while writeback targets r0 and the reader sources r0
    instruction = mk(5'h01, 3'd0, 3'd0, 3'd3, 8'h00);
    writeEnableScalar = 1; writeAddress = 3'd0; writeScalarData = 8'hFF;
    tick();
    idle();
    compared++; if ({writesDest, reg1ScalarContent, reg2ScalarContent} !== {1'b0, 8'h00, 8'h5A})
      begin mismatched++; $display("FAIL r0_bypass: got %b %h %h want 0 00 5a", writesDest, reg1ScalarContent, reg2ScalarContent); end
    inValid = 1; instruction = mk(5'h01, 3'd0, 3'd0, 3'd0, 8'h00);
    tick();
    idle();
    compared++; if (reg1ScalarContent !== 8'h00) begin mismatched++; $display("FAIL r0_readback: got %h want 00", reg1ScalarContent); end
    tick();
  endtask

  task automatic test_saturation_and_reset;
    outReady = 0; inValid = 1; instruction = mk(5'h01, 3'd6, 3'd0, 3'd0, 8'h00);
    tick();
    instruction = mk(5'h01, 3'd0, 3'd6, 3'd0, 8'h00);
    repeat (70000) @(posedge clock);
    @(negedge clock);
    compared++; if (stallCycles !== 16'hFFFF) begin mismatched++; $display("FAIL sat_stall: got %h want ffff", stallCycles); end
    compared++; if ({outValid, inReady} !== 2'b10) begin mismatched++; $display("FAIL sat_held: got %b %b want 1 0", outValid, inReady); end
    reset = 1;
    #1;
    compared++; if ({outValid, opcode, writesDest} !== 7'b0) begin mismatched++; $display("FAIL rst_mid_slot: got %b %h %b want 0 00 0", outValid, opcode, writesDest); end
    compared++; if (stallCycles !== 16'h0) begin mismatched++; $display("FAIL rst_mid_stall: got %h want 0000", stallCycles); end
    @(negedge clock);
    reset = 0;
    #1;
    compared++; if (inReady !== 1'b1) begin mismatched++; $display("FAIL rst_pending: got %b want 1", inReady); end
    instruction = mk(5'h01, 3'd0, 3'd3, 3'd5, 8'h00);
    tick();
    idle();
    compared++; if ({outValid, reg1ScalarContent, reg2ScalarContent} !== {1'b1, 8'h00, 8'h00})
      begin mismatched++; $display("FAIL rst_regfile: got %b %h %h want 1 00 00", outValid, reg1ScalarContent, reg2ScalarContent); end
  endtask

  initial begin
    test_reset();
    test_scalar_read();
    test_raw_stall();
    test_vector_hold_flush();
    test_zero_reg();
    test_saturation_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
